// File: rtl/bomb_timer_ctrl_pkg.sv
// Shared types and defaults for the two-digit countdown sequencer.
// State codes are visible on the state port, so their values are fixed.
package bomb_timer_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONFIG   = 3'd1,
      RUN      = 3'd2,
      DEFUSED  = 3'd3,
      EXPLODED = 3'd4
   } stateT;

   localparam int TICK_DIV_DEF    = 100_000_000;
   localparam int MAX_STRIKES_DEF = 3;

   function automatic int prescWidth(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/bomb_timer_ctrl_rise_edge_det.sv
// Rising-edge detector for a synchronous button level.
// History flop clears on reset, so a level held high through reset reads as a rise.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic prevSig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prevSig <= 1'b0;
      else     prevSig <= sig;
   end

   assign rise = sig & ~prevSig;

endmodule

// File: rtl/bomb_timer_ctrl.sv
// Sequencer for the TEN/ONE countdown digit chain: configure, run,
// 1 Hz borrow tick, strike accounting and terminal defused/exploded states.
module bomb_timer_ctrl
   import bomb_timer_ctrl_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int MAX_STRIKES = MAX_STRIKES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       config_req,
   input  logic       defused,
   input  logic       strike,
   input  logic [3:0] count_ten,
   input  logic [3:0] count_one,
   output logic       reconfig_ten,
   output logic       reconfig_one,
   output logic       tick_one,
   output logic       top_no_borrow,
   output logic [2:0] state,
   output logic [1:0] strikes,
   output logic       exploded,
   output logic       defused_led
);

   localparam int PW = prescWidth(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [2:0] STRIKE_LIM = 3'(MAX_STRIKES);

   stateT stateQ, stateD;
   logic [PW-1:0] prescQ, prescD;
   logic [1:0] strikesQ, strikesD;
   logic recfgQ, recfgD;
   logic tickQ, tickD;
   logic explodedQ, defLedQ;
   logic armRise, cfgRise;
   logic countsZero, tickPoint, strikeLimit;

   rise_edge_det uArmEdge (
      .clk  (clk),
      .rst  (rst),
      .sig  (arm),
      .rise (armRise)
   );

   rise_edge_det uCfgEdge (
      .clk  (clk),
      .rst  (rst),
      .sig  (config_req),
      .rise (cfgRise)
   );

   // Invalid BCD (>9) is simply nonzero here.
   assign countsZero  = ({count_ten, count_one} == 8'h00);
   assign tickPoint   = (prescQ == TICK_LAST);
   assign strikeLimit = strike && (({1'b0, strikesQ} + 3'd1) >= STRIKE_LIM);

   always_comb begin
      stateD   = stateQ;
      prescD   = '0;
      strikesD = strikesQ;
      recfgD   = 1'b0;
      tickD    = 1'b0;
      case (stateQ)
         IDLE: begin
            if (cfgRise) begin
               stateD = CONFIG;
               recfgD = 1'b1;
            end else if (armRise && !countsZero) begin
               stateD = RUN;
            end
         end
         CONFIG: begin
            if (cfgRise) begin
               stateD = IDLE;
               recfgD = 1'b1;
            end
         end
         RUN: begin
            prescD = tickPoint ? '0 : prescQ + 1'b1;
            if (strike && !defused) begin
               strikesD = (strikesQ == 2'd3) ? 2'd3 : strikesQ + 2'd1;
            end
            // defused beats strike limit beats expiry
            if (defused) begin
               stateD = DEFUSED;
            end else if (strikeLimit) begin
               stateD = EXPLODED;
            end else if (tickPoint) begin
               if (countsZero) stateD = EXPLODED;
               else            tickD  = 1'b1;
            end
         end
         DEFUSED, EXPLODED: begin
            stateD = stateQ;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
      if (stateD != RUN) prescD = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ    <= IDLE;
         prescQ    <= '0;
         strikesQ  <= 2'd0;
         recfgQ    <= 1'b0;
         tickQ     <= 1'b0;
         explodedQ <= 1'b0;
         defLedQ   <= 1'b0;
      end else begin
         stateQ    <= stateD;
         prescQ    <= prescD;
         strikesQ  <= strikesD;
         recfgQ    <= recfgD;
         tickQ     <= tickD;
         explodedQ <= (stateD == EXPLODED);
         defLedQ   <= (stateD == DEFUSED);
      end
   end

   assign reconfig_ten  = recfgQ;
   assign reconfig_one  = recfgQ;
   assign tick_one      = tickQ;
   assign top_no_borrow = 1'b1;
   assign state         = stateQ;
   assign strikes       = strikesQ;
   assign exploded      = explodedQ;
   assign defused_led   = defLedQ;

endmodule
